// File: rtl/snes_gamepad_emu.sv
// Device-side SNES gamepad: 4021-style latch/shift register driven from host latch/clk pins.
// Optional turbo auto-release is enabled by defining SNES_TURBO_EN.
`timescale 1ns/1ps

module snes_gamepad_emu #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TURBO_DIV      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] buttons,
    input  logic [15:0] turbo_mask,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        snes_data,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic                   latch_prev_q, latch_prev_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   latch_s, clk_s;
    logic                   latch_rise, latch_fall, clk_rise;

    logic [1:0]       state_q, state_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [4:0]       idx_q, idx_d;
    logic             data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      eff_buttons;

    // Pins are asynchronous to clk; the extra prev flop gives clean one-cycle edge strobes.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], snes_latch};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], snes_clk};
        latch_s      = latch_sync_q[SYNC_STAGES-1];
        clk_s        = clk_sync_q[SYNC_STAGES-1];
        latch_prev_d = latch_s;
        clk_prev_d   = clk_s;
        latch_rise   = latch_s & ~latch_prev_q;
        latch_fall   = ~latch_s & latch_prev_q;
        clk_rise     = clk_s & ~clk_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '1;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b1;
        end else begin
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
            latch_prev_q <= latch_prev_d;
            clk_prev_q   <= clk_prev_d;
        end
    end

`ifdef SNES_TURBO_EN
    localparam int TURBO_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TURBO_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               turbo_phase_q, turbo_phase_d;
    logic               frame_start;

    // A frame starts when the latch falls while loading; phase flips every TURBO_DIV frames.
    always_comb begin
        frame_start   = (state_q == ST_LATCH) && latch_fall;
        frame_cnt_d   = frame_cnt_q;
        turbo_phase_d = turbo_phase_q;
        if (frame_start) begin
            if (frame_cnt_q == TURBO_W'(TURBO_DIV - 1)) begin
                frame_cnt_d   = '0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + TURBO_W'(1);
            end
        end
        eff_buttons = buttons & ~(turbo_mask & {16{turbo_phase_q}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            turbo_phase_q <= turbo_phase_d;
        end
    end
`else
    logic [31:0] unused_turbo;

    assign unused_turbo = {turbo_mask, 16'(TURBO_DIV)};
    assign eff_buttons  = buttons;
`endif

    // Latch beats clock when both strobes land in the same cycle.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_d = 1'b1;
                if (latch_rise) begin
                    state_d  = ST_LATCH;
                    shadow_d = eff_buttons;
                end
            end
            ST_LATCH: begin
                if (latch_fall) begin
                    state_d = ST_SHIFT;
                    idx_d   = 5'd1;
                    data_d  = ~shadow_q[0];
                    cnt_d   = '0;
                end else begin
                    shadow_d = eff_buttons;
                end
            end
            ST_SHIFT: begin
                if (latch_rise) begin
                    state_d  = ST_LATCH;
                    shadow_d = eff_buttons;
                    idx_d    = 5'd0;
                    data_d   = 1'b1;
                end else if (clk_rise) begin
                    cnt_d = '0;
                    if (idx_q[4]) begin
                        state_d      = ST_IDLE;
                        idx_d        = 5'd0;
                        data_d       = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        data_d = ~shadow_q[idx_q[3:0]];
                        idx_d  = idx_q + 5'd1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    idx_d     = 5'd0;
                    data_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
                data_d  = 1'b1;
            end
        endcase

        busy_d = (state_d == ST_LATCH) || (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= 16'h0000;
            idx_q        <= 5'd0;
            data_q       <= 1'b1;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    // While latched, bit 0 follows the shadow so the host sees it before the first clock.
    assign snes_data  = (state_q == ST_LATCH) ? ~shadow_q[0] : data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_snes_gamepad_emu.sv
// Directed self-checking bench for snes_gamepad_emu acting as the SNES host.
// Turbo frames are checked only when SNES_TURBO_EN is defined.
`timescale 1ns/1ps

module tb_snes_gamepad_emu;

    logic        clk;
    logic        rst_n;
    logic [15:0] buttons;
    logic [15:0] turbo_mask;
    logic        snes_latch;
    logic        snes_clk;
    logic        snes_data;
    logic        busy;
    logic        frame_done;
    logic        timeout;

    int          checks;
    int          errors;
    int          fd_count;
    int          fd_base;
    int          wait_n;
    logic [31:0] raw;
    logic        busy_seen;

    snes_gamepad_emu #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(1000),
        .TURBO_DIV     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons   (buttons),
        .turbo_mask(turbo_mask),
        .snes_latch(snes_latch),
        .snes_clk  (snes_clk),
        .snes_data (snes_data),
        .busy      (busy),
        .frame_done(frame_done),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host transaction: optional clock drop so latch and clock rise together,
    // latch pulse, then nclk clocks sampling data just before each rising edge.
    task automatic applyStimulus(input int latch_ns, input int half_ns, input int nclk,
                                 input bit clk_with_latch, input logic [15:0] btn_after);
        raw = 32'h0;
        if (clk_with_latch) begin
            snes_clk = 1'b0;
            #(half_ns);
        end
        snes_latch = 1'b1;
        snes_clk   = 1'b1;
        #(latch_ns);
        busy_seen  = busy;
        snes_latch = 1'b0;
        #(half_ns);
        buttons = btn_after;
        for (int i = 0; i < nclk; i++) begin
            snes_clk = 1'b0;
            #(half_ns);
            raw[i]   = snes_data;
            snes_clk = 1'b1;
            #(half_ns);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fd_count   = 0;
        rst_n      = 1'b0;
        buttons    = 16'h0000;
        turbo_mask = 16'h0000;
        snes_latch = 1'b0;
        snes_clk   = 1'b1;

        #23;
        checkOutput("reset_data", {31'h0, snes_data}, 32'h1);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_frame_done", {31'h0, frame_done}, 32'h0);
        checkOutput("reset_timeout", {31'h0, timeout}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;

        // Basic frame with slow host timing.
        buttons = 16'h7EFE;
        fd_base = fd_count;
        applyStimulus(12000, 3000, 16, 1'b0, 16'h7EFE);
        #100;
        checkOutput("t1_busy_in_latch", {31'h0, busy_seen}, 32'h1);
        checkOutput("t1_word", {16'h0, ~raw[15:0]}, 32'h7EFE);
        checkOutput("t1_frame_done_count", fd_count - fd_base, 1);
        checkOutput("t1_data_after", {31'h0, snes_data}, 32'h1);
        checkOutput("t1_busy_after", {31'h0, busy}, 32'h0);

        // Buttons change after latch fall only affect the next frame.
        buttons = 16'h0001;
        applyStimulus(200, 100, 16, 1'b0, 16'h0100);
        #100;
        checkOutput("t2_word_first", {16'h0, ~raw[15:0]}, 32'h0001);
        fd_base = fd_count;
        applyStimulus(200, 100, 17, 1'b0, 16'h0100);
        #100;
        checkOutput("t2_word_second", {16'h0, ~raw[15:0]}, 32'h0100);
        checkOutput("t2_clk17_data", {31'h0, raw[16]}, 32'h1);
        checkOutput("t2_frame_done_count", fd_count - fd_base, 1);
        checkOutput("t2_data_after", {31'h0, snes_data}, 32'h1);

        // Abort after 5 clocks; re-latch rises together with a clock edge.
        buttons = 16'h0033;
        fd_base = fd_count;
        applyStimulus(200, 100, 5, 1'b0, 16'h0033);
        checkOutput("t3_busy_mid_shift", {31'h0, busy}, 32'h1);
        buttons = 16'h0800;
        applyStimulus(200, 100, 16, 1'b1, 16'h0800);
        #100;
        checkOutput("t3_bit0_after_fall", {31'h0, raw[0]}, 32'h1);
        checkOutput("t3_word", {16'h0, ~raw[15:0]}, 32'h0800);
        checkOutput("t3_frame_done_count", fd_count - fd_base, 1);

        // Stall after 3 clocks: timeout lands 3 sync cycles plus 1000 cycles after the pin rise.
        buttons    = 16'h00F0;
        fd_base    = fd_count;
        snes_latch = 1'b1;
        #200;
        snes_latch = 1'b0;
        #100;
        for (int k = 0; k < 3; k++) begin
            snes_clk = 1'b0;
            #100;
            snes_clk = 1'b1;
            if (k < 2) #100;
        end
        wait_n = 0;
        while (timeout !== 1'b1 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("t4_timeout_latency", wait_n, 1003);
        checkOutput("t4_data_at_timeout", {31'h0, snes_data}, 32'h1);
        checkOutput("t4_busy_at_timeout", {31'h0, busy}, 32'h0);
        @(negedge clk);
        checkOutput("t4_timeout_one_cycle", {31'h0, timeout}, 32'h0);
        checkOutput("t4_no_frame_done", fd_count - fd_base, 0);
        #2;

        // Asynchronous reset mid-shift, placed between clock edges.
        buttons = 16'hFFFF;
        applyStimulus(200, 100, 4, 1'b0, 16'hFFFF);
        checkOutput("t5_data_before_reset", {31'h0, snes_data}, 32'h0);
        checkOutput("t5_busy_before_reset", {31'h0, busy}, 32'h1);
        #4;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_data_in_reset", {31'h0, snes_data}, 32'h1);
        checkOutput("t5_busy_in_reset", {31'h0, busy}, 32'h0);
        #2;
        rst_n = 1'b1;
        #3;
        buttons = 16'hA5C3;
        applyStimulus(200, 100, 16, 1'b0, 16'hA5C3);
        #100;
        checkOutput("t5_word_after_reset", {16'h0, ~raw[15:0]}, 32'hA5C3);

        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        #20;
        buttons = 16'h0100;
`ifdef SNES_TURBO_EN
        turbo_mask = 16'h0100;
        for (int f = 0; f < 8; f++) begin
            applyStimulus(200, 100, 16, 1'b0, 16'h0100);
            #100;
            checkOutput($sformatf("turbo_frame%0d", f), {16'h0, ~raw[15:0]},
                        ((f % 4) < 2) ? 32'h0100 : 32'h0000);
        end
`else
        turbo_mask = 16'hFFFF;
        for (int f = 0; f < 3; f++) begin
            applyStimulus(200, 100, 16, 1'b0, 16'h0100);
            #100;
            checkOutput($sformatf("mask_ignored_frame%0d", f), {16'h0, ~raw[15:0]}, 32'h0100);
        end
`endif

        $display("[TB] directed sequence complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
